ifu_fetch: RTL

- Instruction-fetch stage of the nano RISC-V core.
- Owns the program counter and issues single-outstanding requests on the instruction bus (req/gnt address phase, rvalid response phase).
- Presents fetched {pc, inst} to the IF/ID pipeline register through a one-entry valid/ready output slot.
- Accepts redirects (jump/branch/trap) from execute and discards any in-flight response belonging to the old path.

---
 rtl/ifu_fetch_pkg.sv | 20 ++
 rtl/ifu_fetch_dff.sv | 23 ++
 rtl/ifu_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset level, NOP encoding,
// FSM state encodings and the PC alignment helper.
package ifu_fetch_pkg;

    localparam logic        RstnEnable = 1'b0;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        RSP      = 3'd2,
        DROP_GNT = 3'd3,
        DROP_RSP = 3'd4
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_dff.sv
// Generic clock-enabled register with synchronous active-low reset to a fixed value.
module ifu_fetch_dff
    import ifu_fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] set_data = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rstn == RstnEnable) begin
            q <= set_data;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding ibus fetches and
// presents {pc, inst} through a one-entry valid/ready slot; redirects flush in-flight fetches.
//
// state    | meaning
// IDLE     | no bus activity, waiting for a free output slot
// REQ      | ibus_req asserted for the current pc, waiting for gnt
// RSP      | address accepted, waiting for rvalid to fill the slot
// DROP_GNT | redirected while ungranted; keep old request up until gnt
// DROP_RSP | redirected with a response outstanding; discard next rvalid
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_gnt,
    input  logic            ibus_rvalid,
    input  logic [XLEN-1:0] ibus_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_next;
    logic            pc_ce;
    logic            accept_rsp;
    logic            slot_free;
    logic            bus_gnt;

    assign slot_free  = !out_valid || out_ready;
    assign bus_gnt    = ibus_req && ibus_gnt;
    assign accept_rsp = (state == RSP) && ibus_rvalid && !jump_en;

    assign pc_ce   = jump_en || accept_rsp;
    assign pc_d    = jump_en ? align_pc(jump_addr) : pc + XLEN'(4);
    assign pc_next = pc_ce ? pc_d : pc;

    ifu_fetch_dff #(
        .WIDTH    (XLEN),
        .set_data (RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rstn (rstn),
        .ce   (pc_ce),
        .d    (pc_d),
        .q    (pc)
    );

    always_ff @(posedge clk) begin
        if (rstn == RstnEnable) begin
            state     <= IDLE;
            ibus_req  <= 1'b0;
            ibus_addr <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= INST_NOP;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!jump_en && slot_free) begin
                        state     <= REQ;
                        ibus_req  <= 1'b1;
                        ibus_addr <= pc;
                    end
                end

                REQ: begin
                    // A request already on the bus is never withdrawn, even on redirect.
                    if (jump_en) begin
                        if (bus_gnt) begin
                            state    <= DROP_RSP;
                            ibus_req <= 1'b0;
                        end else begin
                            state <= DROP_GNT;
                        end
                    end else if (bus_gnt) begin
                        state    <= RSP;
                        ibus_req <= 1'b0;
                    end
                end

                RSP: begin
                    if (jump_en) begin
                        state <= ibus_rvalid ? IDLE : DROP_RSP;
                    end else if (ibus_rvalid) begin
                        out_valid <= 1'b1;
                        out_pc    <= pc;
                        out_inst  <= ibus_rdata;
                        if (out_ready) begin
                            state     <= REQ;
                            ibus_req  <= 1'b1;
                            ibus_addr <= pc_next;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                DROP_GNT: begin
                    if (bus_gnt) begin
                        state    <= DROP_RSP;
                        ibus_req <= 1'b0;
                    end
                end

                DROP_RSP: begin
                    if (ibus_rvalid) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    ibus_req <= 1'b0;
                end
            endcase

            // Redirect flushes the consumer, so the slot empties regardless of out_ready.
            if (jump_en) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
